// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory copy engine,
// the data memory and the integration mux.
package dm_pkg;

  localparam int unsigned DM_MEM_DEPTH = 100;
  localparam logic [31:0] DM_ERR_CODE  = 32'hDEAD;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } dm_state_e;

  // 33-bit sum so base+len never wraps
  function automatic logic dm_in_range(
    input logic [31:0] base,
    input logic [31:0] cnt,
    input int unsigned depth
  );
    logic [32:0] sum;
    sum = {1'b0, base} + {1'b0, cnt};
    return sum <= {1'b0, depth};
  endfunction

endpackage

// File: rtl/dm_addr_gen.sv
// Index walker for the copy engine: ascending or descending
// index with last flag, producing src+i and dst+i.
module dm_addr_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        desc_i,
  input  logic [31:0] src_i,
  input  logic [31:0] dst_i,
  input  logic [31:0] len_i,
  input  logic        step_i,
  output logic        last_o,
  output logic [31:0] src_addr_o,
  output logic [31:0] dst_addr_o
);

  logic        desc_q;
  logic [31:0] idx_q;
  logic [31:0] idx_d;
  logic [31:0] end_q;
  logic [31:0] end_d;
  logic [31:0] src_q;
  logic [31:0] dst_q;

  always_comb begin
    idx_d = idx_q;
    end_d = end_q;
    if (load_i) begin
      idx_d = desc_i ? len_i - 32'd1 : 32'd0;
      end_d = desc_i ? 32'd0 : len_i - 32'd1;
    end else if (step_i) begin
      idx_d = desc_q ? idx_q - 32'd1
                     : idx_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      desc_q <= 1'b0;
      idx_q  <= '0;
      end_q  <= '0;
      src_q  <= '0;
      dst_q  <= '0;
    end else begin
      idx_q <= idx_d;
      end_q <= end_d;
      if (load_i) begin
        desc_q <= desc_i;
        src_q  <= src_i;
        dst_q  <= dst_i;
      end
    end
  end

  assign last_o     = (idx_q == end_q);
  assign src_addr_o = src_q + idx_q;
  assign dst_addr_o = dst_q + idx_q;

endmodule

// File: rtl/dm_copy_engine.sv
// Data-memory bus initiator: overlap-safe block copy and
// block fill with up-front range rejection.
module dm_copy_engine
  import dm_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = DM_MEM_DEPTH,
  parameter logic [31:0] ERR_CODE  = DM_ERR_CODE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [31:0] len,
  input  logic [31:0] fill_value,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] err_code,
  output logic        memwrite,
  output logic [31:0] addr,
  output logic [31:0] wd,
  input  logic [31:0] rd
);

  dm_state_e   state_q;
  dm_state_e   state_d;
  logic        mode_q;
  logic [31:0] fill_q;
  logic [31:0] data_q;

  logic        load;
  logic        step;
  logic        cap;
  logic        last;
  logic [31:0] src_a;
  logic [31:0] dst_a;

  logic        src_ok;
  logic        dst_ok;
  logic        reject;
  logic        desc;
  logic [32:0] src_end;

  assign src_ok  = dm_in_range(src_addr, len, MEM_DEPTH);
  assign dst_ok  = dm_in_range(dst_addr, len, MEM_DEPTH);
  assign reject  = !dst_ok || (mode == MODE_COPY && !src_ok);
  assign src_end = {1'b0, src_addr} + {1'b0, len};

  // Destination inside the source window: walk backwards
  assign desc = (mode == MODE_COPY)
             && (dst_addr > src_addr)
             && ({1'b0, dst_addr} < src_end);

  dm_addr_gen u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .desc_i     (desc),
    .src_i      (src_addr),
    .dst_i      (dst_addr),
    .len_i      (len),
    .step_i     (step),
    .last_o     (last),
    .src_addr_o (src_a),
    .dst_addr_o (dst_a)
  );

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    step     = 1'b0;
    cap      = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    err_code = '0;
    memwrite = 1'b0;
    addr     = '0;
    wd       = '0;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          load = 1'b1;
          if (reject)
            state_d = ST_ERR;
          else if (len == 32'd0)
            state_d = ST_DONE;
          else if (mode == MODE_FILL)
            state_d = ST_WRITE;
          else
            state_d = ST_READ;
        end
      end
      ST_READ: begin
        addr    = src_a;
        cap     = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        addr = dst_a;
        // a reset in this cycle must cancel the pending write
        memwrite = !rst;
        wd = (mode_q == MODE_FILL) ? fill_q : data_q;
        if (last) begin
          state_d = ST_DONE;
        end else begin
          step    = 1'b1;
          state_d = (mode_q == MODE_FILL) ? ST_WRITE
                                          : ST_READ;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        err      = 1'b1;
        err_code = ERR_CODE;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_COPY;
      fill_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        mode_q <= mode;
        fill_q <= fill_value;
      end
      if (cap)
        data_q <= rd;
    end
  end

endmodule

// File: tb/tb_dm_copy_engine.sv
// Directed bench for dm_copy_engine with a 100-word
// behavioural memory on its port.
module tb_dm_copy_engine;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [31:0] len;
  logic [31:0] fill_value;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] err_code;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;

  logic [31:0] mem [0:99];
  logic        bd_we;
  logic [6:0]  bd_a;
  logic [31:0] bd_d;

  int n_tests = 0;
  int n_fail  = 0;

  int          t_done;
  int          t_err;
  int          t_end;
  int          n_busy;
  int          n_wr;
  int          n_rd;
  logic [31:0] ec;
  logic [31:0] wr_q [$];

  dm_copy_engine #(
    .MEM_DEPTH (100),
    .ERR_CODE  (32'hDEAD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .fill_value (fill_value),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .memwrite   (memwrite),
    .addr       (addr),
    .wd         (wd),
    .rd         (rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we)
      mem[bd_a] <= bd_d;
    else if (memwrite && addr < 32'd100)
      mem[addr[6:0]] <= wd;
  end

  assign rd = (addr < 32'd100) ? mem[addr[6:0]] : 32'h0;

  task automatic check(
    input string       tag,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, act, exp);
    end
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1;
    bd_a  = 7'(a);
    bd_d  = d;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  // Pulse start, then observe cycle k+c at each negedge
  task automatic go(
    input logic        m,
    input logic [31:0] s,
    input logic [31:0] d,
    input logic [31:0] l,
    input logic [31:0] f,
    input int          inj
  );
    @(negedge clk);
    start = 1'b1;
    mode = m; src_addr = s; dst_addr = d;
    len = l; fill_value = f;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    t_done = -1; t_err = -1; t_end = -1;
    n_busy = 0; n_wr = 0; n_rd = 0; ec = '0;
    wr_q.delete();
    for (int c = 1; c <= 300; c++) begin
      if (c == inj) begin
        start = 1'b1; mode = MODE_FILL;
        dst_addr = 32'd50; len = 32'd1;
        fill_value = 32'h77;
      end else begin
        start = 1'b0;
      end
      if (busy) n_busy++;
      if (memwrite) begin
        n_wr++;
        wr_q.push_back(addr);
      end
      if (busy && !memwrite && !done && !err)
        n_rd++;
      if (done) t_done = c;
      if (err) begin
        t_err = c;
        ec = err_code;
      end
      if (!busy) begin
        t_end = c;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("op_ended", 32'(t_end != -1), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0;
    fill_value = '0;
    bd_we = 1'b0; bd_a = '0; bd_d = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_memwrite", 32'(memwrite), 32'd0);
    rst = 1'b0;
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_wd", wd, 32'd0);
    check("rst_errcode", err_code, 32'd0);

    // Plain copy 10..13 -> 20..23
    for (int i = 0; i < 4; i++) poke(10 + i, 32'(i + 1));
    poke(24, 32'hCAFE);
    go(MODE_COPY, 32'd10, 32'd20, 32'd4, 32'h0, 0);
    check("cp_done_t", t_done, 32'd9);
    check("cp_busy_n", n_busy, 32'd9);
    check("cp_end_t", t_end, 32'd10);
    check("cp_wr_n", n_wr, 32'd4);
    check("cp_rd_n", n_rd, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("cp_dst", mem[20 + i], 32'(i + 1));
      check("cp_src", mem[10 + i], 32'(i + 1));
    end
    check("cp_guard", mem[24], 32'hCAFE);

    // Overlapping copy 0..4 -> 2..6 must walk down
    for (int i = 0; i < 5; i++) poke(i, 32'hA + 32'(i));
    go(MODE_COPY, 32'd0, 32'd2, 32'd5, 32'h0, 0);
    check("ov_done_t", t_done, 32'd11);
    check("ov_wr_n", 32'(wr_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < wr_q.size())
        check("ov_order", wr_q[i], 32'(6 - i));
      check("ov_data", mem[2 + i], 32'hA + 32'(i));
    end

    // Fill up to the last legal word
    go(MODE_FILL, 32'd0, 32'd95, 32'd5, 32'h55, 0);
    check("fl_done_t", t_done, 32'd6);
    check("fl_rd_n", n_rd, 32'd0);
    check("fl_wr_n", n_wr, 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < wr_q.size())
        check("fl_order", wr_q[i], 32'(95 + i));
      check("fl_data", mem[95 + i], 32'h55);
    end

    // Source window runs past the end
    go(MODE_COPY, 32'd98, 32'd0, 32'd3, 32'h0, 0);
    check("rj1_err_t", t_err, 32'd1);
    check("rj1_code", ec, 32'hDEAD);
    check("rj1_wr_n", n_wr, 32'd0);
    check("rj1_done", t_done, 32'hFFFF_FFFF);
    check("rj1_code_idle", err_code, 32'd0);

    // Destination window one word too long
    go(MODE_FILL, 32'd0, 32'd0, 32'd101, 32'h1, 0);
    check("rj2_err_t", t_err, 32'd1);
    check("rj2_code", ec, 32'hDEAD);
    check("rj2_wr_n", n_wr, 32'd0);
    check("rj2_busy_n", n_busy, 32'd1);

    // Zero length completes without touching memory
    go(MODE_COPY, 32'd5, 32'd7, 32'd0, 32'h0, 0);
    check("z_done_t", t_done, 32'd1);
    check("z_wr_n", n_wr, 32'd0);
    check("z_busy_n", n_busy, 32'd1);
    check("z_err", t_err, 32'hFFFF_FFFF);

    // Start pulsed mid-copy must be dropped
    poke(50, 32'h5A5A);
    go(MODE_COPY, 32'd10, 32'd30, 32'd2, 32'h0, 2);
    check("ig_done_t", t_done, 32'd5);
    check("ig_wr_n", n_wr, 32'd2);
    check("ig_mem50", mem[50], 32'h5A5A);
    check("ig_d0", mem[30], 32'd1);
    check("ig_d1", mem[31], 32'd2);
    repeat (3) @(negedge clk);
    check("ig_idle", 32'(busy), 32'd0);

    // Reset during the third WRITE of an 8-word copy
    for (int i = 0; i < 8; i++) begin
      poke(40 + i, 32'h100 + 32'(i));
      poke(60 + i, 32'hEE);
    end
    @(negedge clk);
    start = 1'b1; mode = MODE_COPY;
    src_addr = 32'd40; dst_addr = 32'd60;
    len = 32'd8;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("rs_w3_we", 32'(memwrite), 32'd1);
    check("rs_w3_addr", addr, 32'd62);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rs_busy", 32'(busy), 32'd0);
    t_done = 0;
    n_wr = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) t_done++;
      if (memwrite) n_wr++;
      @(negedge clk);
    end
    check("rs_no_done", t_done, 32'd0);
    check("rs_no_wr", n_wr, 32'd0);
    check("rs_d0", mem[60], 32'h100);
    check("rs_d1", mem[61], 32'h101);
    for (int i = 2; i < 8; i++)
      check("rs_untouched", mem[60 + i], 32'hEE);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_copy_engine.md
# dm_copy_engine

Bus-initiator block that drives the data memory's single port (write enable, word address, write data, combinational read data) to perform block copy and block fill operations without processor involvement. It sits between the control path and the data memory, muxed onto the memory port by the integration layer while `busy` is high. Copies are overlap-safe (memmove semantics); out-of-range requests are rejected before any memory access.

## Interface
Parameters:
- `MEM_DEPTH`, 100: number of 32-bit words in the target memory; valid addresses are 0..MEM_DEPTH-1.
- `ERR_CODE`, 32'hDEAD: value driven on `err_code` when a request is rejected.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request strobe; sampled only in IDLE.
- `mode` in 1: 0 = copy, 1 = fill.
- `src_addr` in 32: first source word address (copy only).
- `dst_addr` in 32: first destination word address.
- `len` in 32: word count.
- `fill_value` in 32: data written in fill mode.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse on successful completion.
- `err` out 1: one-cycle pulse on rejected request.
- `err_code` out 32: ERR_CODE during the `err` pulse, else 0.
- `memwrite` out 1: memory write enable.
- `addr` out 32: memory word address.
- `wd` out 32: memory write data.
- `rd` in 32: memory read data, combinational from `addr` in the same cycle.

## Operation
- States: IDLE, READ, WRITE, DONE, ERR.
- IDLE: `start`=1 latches mode, src, dst, len, fill_value. Range check uses 33-bit sums, with no wrap: reject if dst+len > MEM_DEPTH, or if mode=0 and src+len > MEM_DEPTH. Reject -> ERR. Accept with len=0 -> DONE. Accept in copy mode -> READ. Accept in fill mode -> WRITE.
- Direction: for copy with dst > src and dst < src+len, walk descending from index len-1 to 0. Otherwise walk ascending from 0 to len-1. Fill always walks ascending.
- READ: `addr`=src+i, `memwrite`=0; `rd` captured into the data register at the clock edge. Next state is WRITE.
- WRITE: `addr`=dst+i, `memwrite`=1, `wd`=data register (copy) or fill_value (fill). On the last index -> DONE. Otherwise advance the index, then go to READ (copy) or stay in WRITE (fill).
- DONE: `done`=1 for one cycle -> IDLE. ERR: `err`=1, `err_code`=ERR_CODE for one cycle -> IDLE.
- `start` while not in IDLE is ignored (not queued).
- Outside READ/WRITE: `memwrite`=0, `addr`=0, `wd`=0.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `memwrite`=0; `addr`, `wd`, `err_code`=0; index and data registers 0.
- Reset asserted mid-operation: IDLE on the next edge and no further writes. Words already written remain in memory. No `done`/`err` pulse.
- Latency, with `start` sampled at edge k:
  - Copy of N words: READ at cycle k+1, 2N cycles of READ/WRITE, `done` at cycle k+2N+1.
  - Fill of N words: WRITE cycles k+1..k+N, `done` at k+N+1.
  - len=0: `done` at k+1.
  - Reject: `err` at k+1.
- `busy` rises the cycle after `start` and falls the cycle after the `done`/`err` pulse.
- Each memory write occurs at the rising edge that ends its WRITE cycle.
- The earliest new `start` is accepted in the first IDLE cycle after DONE/ERR.

## Structure
- Shared package `dm_pkg`: state encoding (IDLE, READ, WRITE, DONE, ERR), MEM_DEPTH default, ERR_CODE, and the copy/fill mode constants. The package is shared with the memory and with integration muxing.
- One sub-module is natural: `dm_addr_gen`. It holds the index counter with up/down direction, start/end index load, and a `last` flag, and it outputs src+i and dst+i. The FSM and range check stay in `dm_copy_engine`.

## Test plan
- Preload mem[10..13]=1,2,3,4; copy src=10, dst=20, len=4 -> mem[20..23]=1,2,3,4, `done` at k+9, `busy` high for 9 cycles; mem[10..13] unchanged.
- Overlap: mem[0..4]=A..E; copy src=0, dst=2, len=5 -> mem[2..6]=A..E; the write order observed on `addr` is 6,5,4,3,2.
- Fill dst=95, len=5, fill_value=32'h55 -> mem[95..99]=32'h55, `done` at k+6, no READ cycles (no capture, `memwrite` high for 5 consecutive cycles).
- Range: copy src=98, len=3 and fill dst=0, len=101 -> each `err`=1 with `err_code`=32'hDEAD for one cycle, `memwrite` never asserted; len=0 -> `done` at k+1 with no memory access.
- Assert `rst` during the 3rd WRITE of an 8-word copy -> next cycle IDLE, `busy`=0, only the first 2 destination words are modified, no `done`. A new `start` pulsed while busy in a separate run is ignored.
